// File: rtl/axi4_lite_pkg.sv
// Shared types and defaults for the AXI4-Lite block_ram slave.
// Contents: response codes, FSM state enum, arbiter priority enum, width defaults.
package axi4_lite_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_AXI_ADDR_WIDTH = 18;
    localparam int unsigned DEF_RAM_ADDR_WIDTH = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_READ    = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_RESP = 3'd5
    } bram_slv_state_e;

    typedef enum logic {
        PRIO_WRITE = 1'b0,
        PRIO_READ  = 1'b1
    } prio_e;

endpackage

// File: rtl/axi4_lite_bram_slave_if.sv
// AXI4-Lite bus bundle between an interconnect (master) and the block_ram slave.
// Channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready).
interface axi4_lite_bram_slave_if #(
    parameter int unsigned DATA_WIDTH = axi4_lite_pkg::DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = axi4_lite_pkg::DEF_AXI_ADDR_WIDTH
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_chan_reg.sv
// One-entry holding register for a valid/ready channel.
// Ports: clk, reset (async active-high), in_valid/in_ready/in_data (channel side),
// clear (consumer releases entry), held/data (entry state and payload).
module axi4_lite_chan_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             held,
    output logic [WIDTH-1:0] data
);

    // ready is the inverse of a flop, so it never depends on in_valid
    assign in_ready = ~held;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held <= 1'b0;
            data <= '0;
        end else if (clear) begin
            held <= 1'b0;
        end else if (in_valid && !held) begin
            held <= 1'b1;
            data <= in_data;
        end
    end

endmodule

// File: rtl/axi4_lite_bram_slave.sv
// AXI4-Lite slave front-end for one block_ram: holds AW/W/AR requests, arbitrates
// write vs read round-robin, drives the RAM's single wr_en/rd_en pair and returns B/R.
// Ports: clk, reset (async active-high), axi (slave modport),
// ram_data_in/ram_wr_addr/ram_rd_addr/ram_wr_en/ram_rd_en (to RAM, registered),
// ram_data_out/ram_data_valid (from RAM).
module axi4_lite_bram_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
    parameter int unsigned RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    axi4_lite_bram_slave_if.slave     axi,
    output logic [DATA_WIDTH-1:0]     ram_data_in,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                      ram_wr_en,
    output logic                      ram_rd_en,
    input  logic [DATA_WIDTH-1:0]     ram_data_out,
    input  logic                      ram_data_valid
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned W_WIDTH    = DATA_WIDTH + STRB_WIDTH;

    logic [AXI_ADDR_WIDTH-1:0] aw_addr_full;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_full;
    logic                      unused_addr_bits;

    logic                      aw_held, w_held, ar_held;
    logic                      aw_clear, w_clear, ar_clear;
    logic [RAM_ADDR_WIDTH-1:0] aw_word, ar_word;
    logic [W_WIDTH-1:0]        w_payload;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic [DATA_WIDTH-1:0]     w_data;
    logic                      wr_pend, rd_pend, strb_full;

    bram_slv_state_e           state, state_next;
    prio_e                     prio, prio_next;
    logic                      bvalid, bvalid_next;
    logic [1:0]                bresp, bresp_next;
    logic                      rvalid, rvalid_next;
    logic [1:0]                rresp, rresp_next;
    logic [DATA_WIDTH-1:0]     rdata, rdata_next;
    logic                      wr_en_next, rd_en_next;
    logic [RAM_ADDR_WIDTH-1:0] wr_addr_next, rd_addr_next;
    logic [DATA_WIDTH-1:0]     data_in_next;

    // Byte-offset bits are dropped: the RAM is word addressed
    assign aw_addr_full     = axi.awaddr;
    assign ar_addr_full     = axi.araddr;
    assign unused_addr_bits = ^{aw_addr_full[1:0], ar_addr_full[1:0]};

    axi4_lite_chan_reg #(.WIDTH(RAM_ADDR_WIDTH)) u_aw_reg (
        .clk      (clk),
        .reset    (reset),
        .in_valid (axi.awvalid),
        .in_ready (axi.awready),
        .in_data  (aw_addr_full[RAM_ADDR_WIDTH+1:2]),
        .clear    (aw_clear),
        .held     (aw_held),
        .data     (aw_word)
    );

    axi4_lite_chan_reg #(.WIDTH(W_WIDTH)) u_w_reg (
        .clk      (clk),
        .reset    (reset),
        .in_valid (axi.wvalid),
        .in_ready (axi.wready),
        .in_data  ({axi.wstrb, axi.wdata}),
        .clear    (w_clear),
        .held     (w_held),
        .data     (w_payload)
    );

    axi4_lite_chan_reg #(.WIDTH(RAM_ADDR_WIDTH)) u_ar_reg (
        .clk      (clk),
        .reset    (reset),
        .in_valid (axi.arvalid),
        .in_ready (axi.arready),
        .in_data  (ar_addr_full[RAM_ADDR_WIDTH+1:2]),
        .clear    (ar_clear),
        .held     (ar_held),
        .data     (ar_word)
    );

    assign w_strb    = w_payload[W_WIDTH-1:DATA_WIDTH];
    assign w_data    = w_payload[DATA_WIDTH-1:0];
    assign strb_full = &w_strb;
    assign wr_pend   = aw_held & w_held;
    assign rd_pend   = ar_held;

    assign axi.bvalid = bvalid;
    assign axi.bresp  = bresp;
    assign axi.rvalid = rvalid;
    assign axi.rresp  = rresp;
    assign axi.rdata  = rdata;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            prio        <= PRIO_WRITE;
            bvalid      <= 1'b0;
            bresp       <= RESP_OKAY;
            rvalid      <= 1'b0;
            rresp       <= RESP_OKAY;
            rdata       <= '0;
            ram_wr_en   <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_rd_addr <= '0;
            ram_data_in <= '0;
        end else begin
            state       <= state_next;
            prio        <= prio_next;
            bvalid      <= bvalid_next;
            bresp       <= bresp_next;
            rvalid      <= rvalid_next;
            rresp       <= rresp_next;
            rdata       <= rdata_next;
            ram_wr_en   <= wr_en_next;
            ram_rd_en   <= rd_en_next;
            ram_wr_addr <= wr_addr_next;
            ram_rd_addr <= rd_addr_next;
            ram_data_in <= data_in_next;
        end
    end

    // Next state, arbitration and output next-values
    always_comb begin
        state_next   = state;
        prio_next    = prio;
        bvalid_next  = bvalid;
        bresp_next   = bresp;
        rvalid_next  = rvalid;
        rresp_next   = rresp;
        rdata_next   = rdata;
        wr_en_next   = 1'b0;
        rd_en_next   = 1'b0;
        wr_addr_next = ram_wr_addr;
        rd_addr_next = ram_rd_addr;
        data_in_next = ram_data_in;
        aw_clear     = 1'b0;
        w_clear      = 1'b0;
        ar_clear     = 1'b0;

        case (state)
            ST_IDLE: begin
                // Priority only flips when both kinds actually contended
                if (wr_pend && (!rd_pend || prio == PRIO_WRITE)) begin
                    state_next = ST_WRITE;
                    if (strb_full) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = aw_word;
                        data_in_next = w_data;
                    end
                    if (rd_pend) prio_next = PRIO_READ;
                end else if (rd_pend) begin
                    state_next   = ST_READ;
                    rd_en_next   = 1'b1;
                    rd_addr_next = ar_word;
                    if (wr_pend) prio_next = PRIO_WRITE;
                end
            end
            ST_WRITE: begin
                aw_clear    = 1'b1;
                w_clear     = 1'b1;
                bvalid_next = 1'b1;
                bresp_next  = strb_full ? RESP_OKAY : RESP_SLVERR;
                state_next  = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (axi.bready) begin
                    bvalid_next = 1'b0;
                    state_next  = ST_IDLE;
                end
            end
            ST_READ: begin
                ar_clear   = 1'b1;
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (ram_data_valid) begin
                    rdata_next  = ram_data_out;
                    rresp_next  = RESP_OKAY;
                    rvalid_next = 1'b1;
                    state_next  = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (axi.rready) begin
                    rvalid_next = 1'b0;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_bram_slave.sv
// Directed bench for axi4_lite_bram_slave with a behavioural block_ram and
// scoreboard queues for RAM accesses, B responses and R data.
module tb_axi4_lite_bram_slave;
    import axi4_lite_pkg::*;

    typedef struct packed {
        logic        kind;   // 0 = write, 1 = read
        logic [15:0] addr;
        logic [31:0] data;
    } ram_op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ram_data_in, ram_data_out;
    logic [15:0] ram_wr_addr, ram_rd_addr;
    logic        ram_wr_en, ram_rd_en, ram_data_valid;

    logic [31:0] ram_mem [0:65535];
    logic [31:0] shadow  [0:65535];
    ram_op_t     exp_ram[$];
    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];
    ram_op_t     mon_op;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi4_lite_bram_slave_if axi ();

    axi4_lite_bram_slave dut (
        .clk            (clk),
        .reset          (reset),
        .axi            (axi),
        .ram_data_in    (ram_data_in),
        .ram_wr_addr    (ram_wr_addr),
        .ram_rd_addr    (ram_rd_addr),
        .ram_wr_en      (ram_wr_en),
        .ram_rd_en      (ram_rd_en),
        .ram_data_out   (ram_data_out),
        .ram_data_valid (ram_data_valid)
    );

    // block_ram model: one-cycle registered read with data_valid strobe
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_data_valid <= 1'b0;
            ram_data_out   <= 32'h0;
        end else begin
            if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_data_in;
            ram_data_valid <= ram_rd_en;
            if (ram_rd_en) ram_data_out <= ram_mem[ram_rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM port monitor: exclusivity and access order/content
    always @(negedge clk) begin
        if (!reset && (ram_wr_en || ram_rd_en)) begin
            chk("ram_en_exclusive", 64'(ram_wr_en & ram_rd_en), 64'h0);
            if (exp_ram.size() == 0) begin
                chk("ram_unexpected_access", 64'({ram_wr_en, ram_rd_en}), 64'h0);
            end else begin
                mon_op = exp_ram.pop_front();
                if (ram_wr_en)
                    chk("ram_write", 64'({1'b0, ram_wr_addr, ram_data_in}), 64'(mon_op));
                else
                    chk("ram_read", 64'({1'b1, ram_rd_addr}), 64'({mon_op.kind, mon_op.addr}));
            end
        end
    end

    task automatic exp_write(input logic [17:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (strb == 4'hF) begin
            exp_ram.push_back('{kind: 1'b0, addr: addr[17:2], data: data});
            shadow[addr[17:2]] = data;
            exp_b.push_back(RESP_OKAY);
        end else begin
            exp_b.push_back(RESP_SLVERR);
        end
    endtask

    task automatic exp_read(input logic [17:0] addr);
        exp_ram.push_back('{kind: 1'b1, addr: addr[17:2], data: 32'h0});
        exp_r.push_back(shadow[addr[17:2]]);
    endtask

    // Present the selected requests together; returns 1 ns after the handshake edge
    task automatic drive(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [17:0] awa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [17:0] ara);
        bit ok = 1'b0;
        @(posedge clk); #1;
        axi.awaddr = awa; axi.awvalid = do_aw;
        axi.wdata  = wd;  axi.wstrb   = ws; axi.wvalid = do_w;
        axi.araddr = ara; axi.arvalid = do_ar;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((!do_aw || axi.awready) && (!do_w || axi.wready) && (!do_ar || axi.arready)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_accept_timeout", 64'(ok), 64'h1);
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    endtask

    task automatic wait_b(input int hold);
        bit         seen = 1'b0;
        logic [1:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (axi.bvalid) begin seen = 1'b1; break; end
        end
        chk("b_timeout", 64'(seen), 64'h1);
        if (!seen) return;
        e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
        chk("bresp", 64'(axi.bresp), 64'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("b_hold_valid", 64'(axi.bvalid), 64'h1);
            chk("b_hold_resp", 64'(axi.bresp), 64'(e));
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_drop", 64'(axi.bvalid), 64'h0);
    endtask

    task automatic wait_r(input int hold);
        bit          seen = 1'b0;
        logic [31:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (axi.rvalid) begin seen = 1'b1; break; end
        end
        chk("r_timeout", 64'(seen), 64'h1);
        if (!seen) return;
        e = (exp_r.size() > 0) ? exp_r.pop_front() : 32'hxxxxxxxx;
        chk("rdata", 64'(axi.rdata), 64'(e));
        chk("rresp", 64'(axi.rresp), 64'(RESP_OKAY));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_valid", 64'(axi.rvalid), 64'h1);
            chk("r_hold_data", 64'(axi.rdata), 64'(e));
        end
        axi.rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("r_drop", 64'(axi.rvalid), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        axi.awaddr = '0; axi.awvalid = 1'b0;
        axi.wdata  = '0; axi.wstrb   = '0; axi.wvalid = 1'b0;
        axi.araddr = '0; axi.arvalid = 1'b0;
        axi.bready = 1'b1; axi.rready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bvalid", 64'(axi.bvalid), 64'h0);
        chk("rst_rvalid", 64'(axi.rvalid), 64'h0);
        chk("rst_ram_en", 64'({ram_wr_en, ram_rd_en}), 64'h0);
        chk("rst_rdata", 64'(axi.rdata), 64'h0);
        chk("rst_state", 64'(dut.state), 64'(ST_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'({axi.awready, axi.wready, axi.arready}), 64'h7);

        // AW and W in the same cycle, exact latency
        exp_write(18'h0010, 32'hDEADBEEF, 4'hF);
        drive(1, 1, 0, 18'h0010, 32'hDEADBEEF, 4'hF, 18'h0);
        @(negedge clk);
        chk("wr_t0_en", 64'(ram_wr_en), 64'h0);
        @(negedge clk);
        chk("wr_t1_en", 64'(ram_wr_en), 64'h1);
        chk("wr_t1_addr", 64'(ram_wr_addr), 64'h0004);
        chk("wr_t1_bvalid", 64'(axi.bvalid), 64'h0);
        @(negedge clk);
        chk("wr_t2_bvalid", 64'(axi.bvalid), 64'h1);
        chk("wr_t2_bresp", 64'(axi.bresp), 64'(exp_b.pop_front()));
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_b_drop", 64'(axi.bvalid), 64'h0);

        // Read back, exact latency
        exp_read(18'h0010);
        drive(0, 0, 1, 18'h0, 32'h0, 4'h0, 18'h0010);
        @(negedge clk);
        chk("rd_t0_en", 64'(ram_rd_en), 64'h0);
        @(negedge clk);
        chk("rd_t1_en", 64'(ram_rd_en), 64'h1);
        chk("rd_t1_addr", 64'(ram_rd_addr), 64'h0004);
        @(negedge clk);
        chk("rd_t2_rvalid", 64'(axi.rvalid), 64'h0);
        @(negedge clk);
        chk("rd_t3_rvalid", 64'(axi.rvalid), 64'h1);
        chk("rd_t3_rdata", 64'(axi.rdata), 64'(exp_r.pop_front()));
        chk("rd_t3_rresp", 64'(axi.rresp), 64'(RESP_OKAY));
        @(posedge clk); #1;

        // W ahead of AW: nothing happens until AW is held
        exp_write(18'h0020, 32'hCAFEF00D, 4'hF);
        drive(0, 1, 0, 18'h0, 32'hCAFEF00D, 4'hF, 18'h0);
        repeat (2) begin
            @(negedge clk);
            chk("wlead_no_wr", 64'(ram_wr_en), 64'h0);
            chk("wlead_no_b", 64'(axi.bvalid), 64'h0);
        end
        drive(1, 0, 0, 18'h0020, 32'h0, 4'h0, 18'h0);
        wait_b(0);
        repeat (3) begin
            @(negedge clk);
            chk("wlead_single_b", 64'(axi.bvalid), 64'h0);
        end
        exp_read(18'h0020);
        drive(0, 0, 1, 18'h0, 32'h0, 4'h0, 18'h0020);
        wait_r(0);

        // Partial strobe: SLVERR, RAM untouched; read via aliased byte offset
        exp_write(18'h0010, 32'h12345678, 4'b0011);
        drive(1, 1, 0, 18'h0010, 32'h12345678, 4'b0011, 18'h0);
        wait_b(0);
        exp_read(18'h0013);
        drive(0, 0, 1, 18'h0, 32'h0, 4'h0, 18'h0013);
        wait_r(0);

        // Contention #1: write wins
        exp_write(18'h0030, 32'h11111111, 4'hF);
        exp_read(18'h0010);
        drive(1, 1, 1, 18'h0030, 32'h11111111, 4'hF, 18'h0010);
        wait_b(0);
        wait_r(0);

        // Contention #2: read wins and sees the pre-write value
        exp_read(18'h0030);
        exp_write(18'h0030, 32'h22222222, 4'hF);
        drive(1, 1, 1, 18'h0030, 32'h22222222, 4'hF, 18'h0030);
        wait_r(0);
        wait_b(0);
        exp_read(18'h0030);
        drive(0, 0, 1, 18'h0, 32'h0, 4'h0, 18'h0030);
        wait_r(0);

        // Backpressure on B and R for 5 cycles
        axi.bready = 1'b0;
        exp_write(18'h0040, 32'hA5A5A5A5, 4'hF);
        drive(1, 1, 0, 18'h0040, 32'hA5A5A5A5, 4'hF, 18'h0);
        wait_b(5);
        axi.rready = 1'b0;
        exp_read(18'h0040);
        drive(0, 0, 1, 18'h0, 32'h0, 4'h0, 18'h0040);
        wait_r(5);

        // Reset in RD_WAIT: everything drops at once, request discarded
        exp_ram.push_back('{kind: 1'b1, addr: 16'h0008, data: 32'h0});
        drive(0, 0, 1, 18'h0, 32'h0, 4'h0, 18'h0020);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rd_en", 64'(ram_rd_en), 64'h1);
        @(posedge clk); #1;
        chk("pre_rst_state", 64'(dut.state), 64'(ST_RD_WAIT));
        reset = 1'b1;
        #1;
        chk("mid_rst_state", 64'(dut.state), 64'(ST_IDLE));
        chk("mid_rst_valids", 64'({axi.bvalid, axi.rvalid}), 64'h0);
        chk("mid_rst_ram_en", 64'({ram_wr_en, ram_rd_en}), 64'h0);
        chk("mid_rst_rdata", 64'(axi.rdata), 64'h0);
        chk("mid_rst_rd_addr", 64'(ram_rd_addr), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'({axi.awready, axi.wready, axi.arready}), 64'h7);
        chk("post_rst_ram_q", 64'(exp_ram.size()), 64'h0);
        exp_read(18'h0040);
        drive(0, 0, 1, 18'h0, 32'h0, 4'h0, 18'h0040);
        wait_r(0);

        repeat (3) @(negedge clk);
        chk("end_b_q", 64'(exp_b.size()), 64'h0);
        chk("end_r_q", 64'(exp_r.size()), 64'h0);
        chk("end_ram_q", 64'(exp_ram.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
